// File: rtl/mux_n_arb_reg.sv
// N-channel registered mux with request/grant handshake, fixed or round-robin arbitration and a valid/ready output.
// Optional build macro: MUX_ARB_TRISTATE_EN (enable low tri-states mux_out and hides out_valid).
module mux_n_arb_reg #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2
) (
  input  logic                      clock,
  input  logic                      reset_b,
  input  logic                      enable,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          select,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  output logic [CHANNELS-1:0]       grant,
  output logic [WIDTH-1:0]          mux_out,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   rr_q, rr_d;
  logic               valid_vis;
  logic               can_load;
  logic               gnt_vld;
  logic [SEL_W-1:0]   gnt_idx;
  logic [SEL_W-1:0]   idx;
  logic [WIDTH-1:0]   load_data;

  // Visible output view of the register; the tristate build hides it while enable is low
`ifdef MUX_ARB_TRISTATE_EN
  assign valid_vis = (state_q == FULL) & enable;
  assign mux_out   = enable ? data_q : {WIDTH{1'bz}};
`else
  assign valid_vis = (state_q == FULL);
  assign mux_out   = data_q;
`endif

  assign out_valid = valid_vis;
  assign out_sel   = sel_q;
  assign can_load  = enable & (~valid_vis | out_ready);

  // Arbitration: fixed candidate or first requester after rr_q, wrapping
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    if (!mode) begin
      if ((32'(select) < CHANNELS) && req[select]) begin
        gnt_vld = 1'b1;
        gnt_idx = select;
      end
    end else begin
      for (int unsigned i = 1; i <= CHANNELS; i++) begin
        idx = SEL_W'((32'(rr_q) + i) % CHANNELS);
        if (!gnt_vld && req[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = idx;
        end
      end
    end
    gnt_vld = gnt_vld & can_load & reset_b;
  end

  assign grant = gnt_vld ? (CHANNELS'(1) << gnt_idx) : '0;

  always_comb begin
    load_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (gnt_idx == SEL_W'(k)) load_data = data_in[k*WIDTH +: WIDTH];
    end
  end

  // Next-state: grant loads (even while draining), otherwise a drain empties
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    rr_d    = rr_q;
    if (gnt_vld) begin
      state_d = FULL;
      data_d  = load_data;
      sel_d   = gnt_idx;
      if (mode) rr_d = gnt_idx;
    end else if (valid_vis && out_ready) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      rr_q    <= SEL_W'(CHANNELS - 1);
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
    end
  end

endmodule

// File: tb/tb_mux_n_arb_reg.sv
// Scoreboard bench for mux_n_arb_reg: a small arbitration model predicts grants and the output register.
module tb_mux_n_arb_reg;

  logic         clock = 1'b0;
  logic         reset_b;
  logic         enable;
  logic         mode;
  logic [1:0]   select;
  logic [3:0]   req;
  logic [127:0] data_in;
  logic [3:0]   grant;
  logic [31:0]  mux_out;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic         out_ready;

  logic [2:0]   grant3;
  logic [31:0]  mux_out3;
  logic [1:0]   out_sel3;
  logic         out_valid3;

  always #5 clock = ~clock;

  mux_n_arb_reg #(.WIDTH(32), .CHANNELS(4), .SEL_W(2)) u_dut (
    .clock(clock), .reset_b(reset_b), .enable(enable), .mode(mode), .select(select),
    .req(req), .data_in(data_in), .grant(grant), .mux_out(mux_out), .out_sel(out_sel),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_n_arb_reg #(.WIDTH(32), .CHANNELS(3), .SEL_W(2)) u_dut3 (
    .clock(clock), .reset_b(reset_b), .enable(enable), .mode(mode), .select(select),
    .req(req[2:0]), .data_in(data_in[95:0]), .grant(grant3), .mux_out(mux_out3),
    .out_sel(out_sel3), .out_valid(out_valid3), .out_ready(out_ready)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  bit          m_full;
  logic [31:0] m_data;
  logic [1:0]  m_sel;
  logic [1:0]  m_rr;
  int          n_vec;
  int          n_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One clock: predict and check grant, then check the register after the edge
  task automatic cycle(input string tag);
    logic [3:0]  eg;
    logic        can;
    int unsigned ei;
    bit          hit;
    exp_t        e;
    #1;
    eg  = '0;
    hit = 1'b0;
    ei  = 0;
    can = enable & (!m_full | out_ready);
    if (!mode) begin
      if (req[select]) begin hit = 1'b1; ei = select; end
    end else begin
      for (int i = 1; i <= 4; i++) begin
        if (!hit && req[(m_rr + i) % 4]) begin hit = 1'b1; ei = (m_rr + i) % 4; end
      end
    end
    hit = hit & can;
    if (hit) begin
      eg[ei] = 1'b1;
      sb.push_back({2'(ei), data_in[ei*32 +: 32]});
      if (mode) m_rr = 2'(ei);
    end
    check({tag, ":grant"}, 64'(grant), 64'(eg));
    @(posedge clock);
    #1;
    if (hit) m_full = 1'b1;
    else if (m_full && out_ready) m_full = 1'b0;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      m_data = e.data;
      m_sel  = e.sel;
    end
    check({tag, ":valid"}, 64'(out_valid), 64'(m_full));
    check({tag, ":data"}, 64'(mux_out), 64'(m_data));
    check({tag, ":sel"}, 64'(out_sel), 64'(m_sel));
  endtask

  // Asynchronous reset: outputs must clear without waiting for an edge
  task automatic do_reset(input string tag);
    reset_b = 1'b0;
    #1;
    check({tag, ":rst_valid"}, 64'(out_valid), 64'd0);
    check({tag, ":rst_data"}, 64'(mux_out), 64'd0);
    check({tag, ":rst_sel"}, 64'(out_sel), 64'd0);
    check({tag, ":rst_grant"}, 64'(grant), 64'd0);
    m_full = 1'b0;
    m_data = '0;
    m_sel  = '0;
    m_rr   = 2'd3;
    sb.delete();
    @(posedge clock);
    @(posedge clock);
    #1;
    reset_b = 1'b1;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    enable    = 1'b1;
    mode      = 1'b0;
    select    = 2'd0;
    req       = 4'b1111;
    out_ready = 1'b1;
    data_in   = {32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};
    do_reset("init");

    // select beyond a 3-channel instance never grants
    mode = 1'b0; select = 2'd3; req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      cycle("sel_oob");
      check("sel_oob:grant3", 64'(grant3), 64'd0);
      check("sel_oob:valid3", 64'(out_valid3), 64'd0);
    end

    select = 2'd2; req = 4'b0100;
    cycle("fixed2");
    req = 4'b0000;
    cycle("drain");

    // round-robin with all requesting: 0,1,2,3,0 back to back
    data_in = {$urandom, $urandom, $urandom, $urandom};
    mode = 1'b1; req = 4'b1111;
    for (int i = 0; i < 5; i++) cycle("rr_all");

    // back-pressure then drain-and-reload in one edge
    mode = 1'b0; select = 2'd1; req = 4'b0010;
    cycle("bp_load");
    data_in[63:32] = 32'h1234_5678;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("bp_hold");
    out_ready = 1'b1;
    cycle("bp_reload");

    mode = 1'b1; req = 4'b1000;
    cycle("rr_ch3");
    req = 4'b1001;
    cycle("rr_wrap");

    req = 4'b1111;
    do_reset("mid");
    req = 4'b0011;
    cycle("post_rst0");
    cycle("post_rst1");

    // enable low: held data stays valid, can still drain, no new grants
    req = 4'b1111;
    enable = 1'b0; out_ready = 1'b0;
    cycle("en_hold");
    out_ready = 1'b1;
    cycle("en_drain");
    cycle("en_idle");
    enable = 1'b1;
    cycle("en_back");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux_n_arb_reg.md
# mux_n_arb_reg

Parametrised N-channel, W-bit registered multiplexer with a per-channel request/grant handshake, selectable fixed-select or round-robin arbitration, and a valid/ready output register. It is the successor to the 4-to-1, 32-bit combinational enable mux. It sits between multiple producers and a single downstream consumer and sustains one transfer per clock.

## Interface
Parameters:
- WIDTH, 32, data width per channel.
- CHANNELS, 4, number of input channels (2..16).
- SEL_W, 2, select/pointer width; CHANNELS <= 2**SEL_W is required.

Ports:
- clock  input  1  rising-edge clock.
- reset_b  input  1  asynchronous, active-low reset.
- enable  input  1  arbitration enable; when low, no new grants are issued.
- mode  input  1  0 = fixed select, 1 = round-robin.
- select  input  SEL_W  channel index used in fixed mode.
- req  input  CHANNELS  per-channel request; data is held stable while the request is high.
- data_in  input  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- grant  output  CHANNELS  combinational one-hot; channel k's data is consumed at this edge.
- mux_out  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  index of the channel held in the output register.
- out_valid  output  1  output register holds data.
- out_ready  input  1  consumer accepts when out_valid and out_ready are both high.

## Operation
- Output register has two states, EMPTY (out_valid=0) and FULL (out_valid=1).
- can_load = enable & (~out_valid | out_ready).
- Fixed mode: the candidate is the channel at `select`. A grant is issued if select < CHANNELS, req[select] is high and can_load is high. If select >= CHANNELS, no grant is issued and the state is unchanged.
- Round-robin mode:
  - The search starts at (rr_ptr+1) mod CHANNELS and wraps.
  - The first requesting channel is granted when can_load is high.
  - On a grant, rr_ptr is set to the granted index.
- rr_ptr does not update in fixed mode or when there is no grant.
- State transitions on a grant:
  - The register loads data_in of the granted channel and out_sel loads its index.
  - State becomes FULL.
- Drain without a grant (out_valid & out_ready & no grant): state becomes EMPTY; mux_out and out_sel hold their last values.
- Simultaneous drain and grant: the register reloads and stays FULL. No bubble is inserted.
- FULL with out_ready low: grant is 0 for all channels and the data is held stable.
- enable low: no grants. Held data stays valid and can still be drained, unless the tristate option below is compiled in.
- Mode or select changes take effect in the same cycle's arbitration. No transfer in flight is corrupted.
- Reset, asynchronous at any time, including mid-transfer:
  - mux_out=0, out_sel=0, out_valid=0.
  - rr_ptr=CHANNELS-1, so channel 0 has first priority.
  - grant=0 while reset_b is low.

## Timing
- Latency: one clock from grant to out_valid/mux_out.
- Throughput: one transfer per clock when out_ready is held high.
- grant is a combinational function of req, mode, select, enable, out_valid, out_ready and rr_ptr. There is no combinational path from data_in to any output.
- Producers see acceptance at the rising edge where grant[k]=1 and then update or drop req.

## Configuration
- MUX_ARB_TRISTATE_EN defined:
  - When enable is low, mux_out is driven to all 'z and out_valid is forced to 0.
  - Draining is blocked, and the register contents and state are retained.
  - When enable returns high, the previous out_valid and data reappear.
- Not defined: mux_out and out_valid always reflect the register, and enable gates only the grants.

## Test plan
- Reset then fixed mode with select=2, req=4'b0100, data_in ch2=32'hA5A5_0002, out_ready=1: grant=4'b0100 in cycle 0; cycle 1 shows out_valid=1, mux_out=32'hA5A5_0002, out_sel=2.
- Round-robin, req=4'b1111 held, out_ready=1: grants go 0,1,2,3,0 on consecutive cycles and out_valid stays high with no bubbles.
- Back-pressure: FULL with ch1 data, out_ready=0 for 3 cycles and req=4'b0010: grant=0 and mux_out is stable. out_ready=1 then causes drain and reload in the same edge.
- Fixed mode select=3 with CHANNELS=3: no grant ever and out_valid stays 0. Round-robin with req=4'b1001 after ch3 was granted: next grant goes to ch0 (wrap).
- Assert reset_b low mid-stream while FULL: out_valid=0, mux_out=0 immediately (asynchronous). After release with req=4'b0011 in round-robin mode, ch0 is granted first.
- Drop enable while FULL:
  - Without MUX_ARB_TRISTATE_EN, a drain still occurs and no grant is issued.
  - With it, mux_out=32'hzzzz_zzzz and out_valid=0. When enable returns, the previous data is restored.
